// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: legal key sizes, word-count derivations,
// FSM encoding and the round-constant start value.
package aes_pkg;

    localparam int KEY_BITS_128 = 128;
    localparam int KEY_BITS_192 = 192;
    localparam int KEY_BITS_256 = 256;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return nk_of(key_bits) + 6;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x127, inv;

    // inverse = x^254, built by an addition chain; maps 0 to 0 as AES requires
    always_comb begin
        x2   = gf_mul(byte_in, byte_in);
        x3   = gf_mul(x2, byte_in);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x126 = gf_mul(x120, x6);
        x127 = gf_mul(x126, byte_in);
        inv  = gf_mul(x127, x127);
        byte_out = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key expansion, one word per cycle, with a round-key read port.
// Optional AES_KEYEXP_DEC_ORDER_EN adds rd_rev for reverse (decryption) round order.
//
// state  | meaning
// IDLE   | waiting for start; key store readable when keys_ready
// EXPAND | writing w[i] each cycle until w[NW-1]
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int KEY_BITS = KEY_BITS_128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                rd_en,
    input  logic [3:0]          rd_round,
`ifdef AES_KEYEXP_DEC_ORDER_EN
    input  logic                rd_rev,
`endif
    output logic                busy,
    output logic                done,
    output logic                keys_ready,
    output logic [127:0]        rk_out,
    output logic                rk_valid
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);

    state_t      state, state_nxt;
    logic [5:0]  idx;
    logic [2:0]  kmod;
    logic [7:0]  rcon;
    logic [31:0] w [NW];

    logic        accept, write_en, last_word;
    logic [31:0] prev, back, sub_in, sub_out, temp, w_new;
    logic [3:0]  eff_round;
    logic [5:0]  base;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        accept    = 1'b0;
        write_en  = 1'b0;
        last_word = (idx == 6'(NW - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                busy     = 1'b1;
                write_en = 1'b1;
                if (last_word) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One shared SubWord path: its input is RotWord'd only on the i mod Nk == 0 words.
    always_comb begin
        prev   = w[idx - 6'd1];
        back   = w[idx - 6'(NK)];
        sub_in = (kmod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        if (kmod == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (NK == 8 && kmod == 3'd4)
            temp = sub_out;
        else
            temp = prev;
        w_new = back ^ temp;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_in  (sub_in[8*b +: 8]),
            .byte_out (sub_out[8*b +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 6'd0;
            kmod       <= 3'd0;
            rcon       <= RCON_INIT;
            done       <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                idx        <= 6'(NK);
                kmod       <= 3'd0;
                rcon       <= RCON_INIT;
                keys_ready <= 1'b0;
            end else if (write_en) begin
                idx  <= idx + 6'd1;
                kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
                if (kmod == 3'd0) rcon <= xtime(rcon);
                if (last_word) begin
                    done       <= 1'b1;
                    keys_ready <= 1'b1;
                end
            end
        end
    end

    // Word store is never reset; keys_ready gates every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NK; k++)
                w[k] <= key_in[KEY_BITS-1-32*k -: 32];
        end else if (write_en) begin
            w[idx] <= w_new;
        end
    end

`ifdef AES_KEYEXP_DEC_ORDER_EN
    assign eff_round = rd_rev ? 4'(NR) - rd_round : rd_round;
`else
    assign eff_round = rd_round;
`endif
    assign base = {eff_round, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_out   <= 128'h0;
        end else begin
            rk_valid <= 1'b0;
            if (rd_en) begin
                if (keys_ready && rd_round <= 4'(NR)) begin
                    rk_valid <= 1'b1;
                    rk_out   <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
                end else begin
                    rk_out <= 128'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq with FIPS-197 vectors at all three key sizes.
module tb_aes_key_expand_seq;

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RZERO_1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, rd_en = 1'b0;
    logic [3:0]   rd_round = 4'd0;
    logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [127:0] key_a = '0;
    logic [191:0] key_b = '0;
    logic [255:0] key_c = '0;
`ifdef AES_KEYEXP_DEC_ORDER_EN
    logic         rd_rev = 1'b0;
`endif
    logic busy_a, done_a, ready_a, valid_a;
    logic busy_b, done_b, ready_b, valid_b;
    logic busy_c, done_c, ready_c, valid_c;
    logic [127:0] rk_a, rk_b, rk_c;

    int errors = 0;
    int checks = 0;
    int n;

    aes_key_expand_seq #(.KEY_BITS(128)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_a), .rd_en(rd_en), .rd_round(rd_round),
`ifdef AES_KEYEXP_DEC_ORDER_EN
        .rd_rev(rd_rev),
`endif
        .busy(busy_a), .done(done_a), .keys_ready(ready_a), .rk_out(rk_a), .rk_valid(valid_a));

    aes_key_expand_seq #(.KEY_BITS(192)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key_in(key_b), .rd_en(rd_en), .rd_round(rd_round),
`ifdef AES_KEYEXP_DEC_ORDER_EN
        .rd_rev(1'b0),
`endif
        .busy(busy_b), .done(done_b), .keys_ready(ready_b), .rk_out(rk_b), .rk_valid(valid_b));

    aes_key_expand_seq #(.KEY_BITS(256)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .key_in(key_c), .rd_en(rd_en), .rd_round(rd_round),
`ifdef AES_KEYEXP_DEC_ORDER_EN
        .rd_rev(1'b0),
`endif
        .busy(busy_c), .done(done_c), .keys_ready(ready_c), .rk_out(rk_c), .rk_valid(valid_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Counts edges after the start edge until done is seen; gives up at 200.
    task automatic wait_done(input int sel, inout int cnt);
        while (cnt < 200) begin
            tick();
            cnt++;
            if (done_of(sel)) break;
        end
    endtask

    task automatic rd(input logic [3:0] r);
        rd_en    = 1'b1;
        rd_round = r;
        tick();
        rd_en    = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_b("rst_busy", busy_a, 1'b0);
        chk_b("rst_done", done_a, 1'b0);
        chk_b("rst_ready", ready_a, 1'b0);
        chk_b("rst_valid", valid_a, 1'b0);
        chk_v("rst_rk", rk_a, 128'h0);
        rd(4'd0);
        chk_b("rd_before_keys_valid", valid_a, 1'b0);
        chk_v("rd_before_keys_rk", rk_a, 128'h0);

        key_a = K128; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk_b("k128_busy", busy_a, 1'b1);
        chk_b("k128_ready_low", ready_a, 1'b0);
        n = 0;
        wait_done(0, n);
        chk_i("k128_done_cycles", n, 40);
        chk_b("k128_ready", ready_a, 1'b1);
        chk_b("k128_busy_off", busy_a, 1'b0);
        tick();
        chk_b("k128_done_pulse", done_a, 1'b0);
        rd(4'd10);
        chk_b("k128_r10_valid", valid_a, 1'b1);
        chk_v("k128_r10", rk_a, R128_10);
        tick();
        chk_b("k128_valid_drop", valid_a, 1'b0);
        chk_v("k128_rk_hold", rk_a, R128_10);
        rd(4'd1);
        chk_v("k128_r1", rk_a, R128_1);
        rd(4'd0);
        chk_v("k128_r0", rk_a, K128);
        rd(4'd11);
        chk_b("k128_r11_valid", valid_a, 1'b0);
        chk_v("k128_r11_rk", rk_a, 128'h0);

        key_a = '0; start_a = 1'b1; rd_en = 1'b1; rd_round = 4'd10;
        tick();
        start_a = 1'b0; rd_en = 1'b0;
        chk_b("same_edge_valid", valid_a, 1'b1);
        chk_v("same_edge_old_keys", rk_a, R128_10);
        chk_b("same_edge_ready_low", ready_a, 1'b0);
        n = 0;
        wait_done(0, n);
        chk_i("zero_done_cycles", n, 40);
        rd(4'd1);
        chk_v("zero_r1", rk_a, RZERO_1);

        key_a = K128; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        repeat (4) begin tick(); n++; end
        start_a = 1'b1; key_a = {128{1'b1}};
        tick();
        n++;
        start_a = 1'b0;
        wait_done(0, n);
        chk_i("restart_ignored_cycles", n, 40);
        rd(4'd10);
        chk_v("restart_ignored_r10", rk_a, R128_10);
        rd(4'd15);
        chk_b("r15_valid", valid_a, 1'b0);
        chk_v("r15_rk", rk_a, 128'h0);

`ifdef AES_KEYEXP_DEC_ORDER_EN
        rd_rev = 1'b1;
        rd(4'd0);
        rd_rev = 1'b0;
        chk_v("rev_r0", rk_a, R128_10);
`endif

        key_b = K192; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        wait_done(1, n);
        chk_i("k192_done_cycles", n, 46);
        rd(4'd12);
        chk_b("k192_r12_valid", valid_b, 1'b1);
        chk_v("k192_r12", rk_b, R192_12);
        rd(4'd13);
        chk_b("k192_r13_valid", valid_b, 1'b0);

        key_c = K256; start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n = 0;
        wait_done(2, n);
        chk_i("k256_done_cycles", n, 52);
        rd(4'd14);
        chk_v("k256_r14", rk_c, R256_14);
        rd(4'd0);
        chk_v("k256_r0", rk_c, R256_0);

        key_a = K128; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_b("abort_ready", ready_a, 1'b0);
        chk_b("abort_busy", busy_a, 1'b0);
        rd(4'd10);
        chk_b("abort_rd_valid", valid_a, 1'b0);
        chk_v("abort_rd_rk", rk_a, 128'h0);
        chk_b("abort_k256_valid", valid_c, 1'b0);
        repeat (45) tick();
        chk_b("abort_stays_idle", ready_a, 1'b0);
        key_a = K128; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        wait_done(0, n);
        chk_i("fresh_done_cycles", n, 40);
        rd(4'd10);
        chk_v("fresh_r10", rk_a, R128_10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
